iob_ibex_axi_arb: RTL and testbench

- Shares one AXI4 master port between the Ibex instruction-fetch port (read-only) and the Ibex LSU data port (read/write).
- Sits between the Ibex core and the system AXI interconnect.
- Arbitrates the two OBI-style requesters and sequences one single-beat AXI transaction at a time.
- Returns each response to the port that owns it.

---
 rtl/iob_ibex_axi_arb.sv | 214 +++++++++++++++++++++
 tb/tb_iob_ibex_axi_arb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_ibex_axi_arb.sv
// iob_ibex_axi_arb
// Shares one AXI4 master port between the Ibex instruction-fetch port
// (read-only) and the Ibex LSU data port (read/write). One single-beat AXI
// transaction is outstanding at a time. Each response is returned to the
// port that issued the request.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   instr_*                   OBI-style instruction port (req/gnt/addr/rvalid/rdata/err)
//   data_*                    OBI-style LSU port (req/gnt/we/be/addr/wdata/rvalid/rdata/err)
//   aw*/w*/b*                 AXI write address, write data and write response channels
//   ar*/r*                    AXI read address and read data channels
//
// Build option:
//   IOB_IBEX_AXI_ARB_RR_EN    defined: round-robin arbitration on simultaneous
//                             requests (ARB_HOLD=1 keeps data priority on ties);
//                             undefined: fixed priority, data port wins ties.
//
// gnt outputs are combinational; every other output is registered.
module iob_ibex_axi_arb #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int ARB_HOLD   = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // instruction port
  input  logic                    instr_req_i,
  output logic                    instr_gnt_o,
  input  logic [AXI_ADDR_W-1:0]   instr_addr_i,
  output logic                    instr_rvalid_o,
  output logic [31:0]             instr_rdata_o,
  output logic                    instr_err_o,
  // data port
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  input  logic                    data_we_i,
  input  logic [3:0]              data_be_i,
  input  logic [AXI_ADDR_W-1:0]   data_addr_i,
  input  logic [31:0]             data_wdata_i,
  output logic                    data_rvalid_o,
  output logic [31:0]             data_rdata_o,
  output logic                    data_err_o,
  // AXI write address
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [AXI_ADDR_W-1:0]   awaddr_o,
  // AXI write data
  output logic                    wvalid_o,
  input  logic                    wready_i,
  output logic [AXI_DATA_W-1:0]   wdata_o,
  output logic [AXI_DATA_W/8-1:0] wstrb_o,
  // AXI write response
  input  logic                    bvalid_i,
  output logic                    bready_o,
  input  logic [1:0]              bresp_i,
  // AXI read address
  output logic                    arvalid_o,
  input  logic                    arready_i,
  output logic [AXI_ADDR_W-1:0]   araddr_o,
  // AXI read data
  input  logic                    rvalid_i,
  output logic                    rready_o,
  input  logic [AXI_DATA_W-1:0]   rdata_i,
  input  logic [1:0]              rresp_i
);

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    AWW,
    B,
    RESP
  } state_t;

  state_t state_q;
  logic   owner_data_q;   // 1 = data port owns the outstanding transaction
  logic   tie_to_data;    // winner when both ports request in the same cycle

  // Low address bits are dropped (word-aligned AXI) and only the error bit of
  // each response code matters.
  logic unused_bits;
  assign unused_bits = ^{instr_addr_i[1:0], data_addr_i[1:0], rresp_i[0], bresp_i[0]};

`ifdef IOB_IBEX_AXI_ARB_RR_EN
  logic rr_data_q;        // 1 = data port is favoured on the next tie
  assign tie_to_data = (ARB_HOLD != 0) || rr_data_q;
`else
  // Fixed priority: the hold setting cannot change the outcome here.
  assign tie_to_data = (ARB_HOLD != 0) || 1'b1;
`endif

  // Grants only exist in IDLE and never while reset is being applied, so a
  // grant always corresponds to a captured transaction.
  always_comb begin
    instr_gnt_o = 1'b0;
    data_gnt_o  = 1'b0;
    if (state_q == IDLE && !rst_i) begin
      if (instr_req_i && data_req_i) begin
        data_gnt_o  = tie_to_data;
        instr_gnt_o = !tie_to_data;
      end else begin
        data_gnt_o  = data_req_i;
        instr_gnt_o = instr_req_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      owner_data_q   <= 1'b0;
      awvalid_o      <= 1'b0;
      wvalid_o       <= 1'b0;
      bready_o       <= 1'b0;
      arvalid_o      <= 1'b0;
      rready_o       <= 1'b0;
      instr_rvalid_o <= 1'b0;
      data_rvalid_o  <= 1'b0;
      instr_err_o    <= 1'b0;
      data_err_o     <= 1'b0;
      instr_rdata_o  <= '0;
      data_rdata_o   <= '0;
`ifdef IOB_IBEX_AXI_ARB_RR_EN
      rr_data_q      <= 1'b1;
`endif
    end else begin
      // Response pulses last exactly one cycle (the RESP state).
      instr_rvalid_o <= 1'b0;
      data_rvalid_o  <= 1'b0;
      instr_err_o    <= 1'b0;
      data_err_o     <= 1'b0;

      case (state_q)
        IDLE: begin
          if (data_gnt_o || instr_gnt_o) begin
            owner_data_q <= data_gnt_o;
`ifdef IOB_IBEX_AXI_ARB_RR_EN
            rr_data_q    <= !data_gnt_o;
`endif
            if (data_gnt_o && data_we_i) begin
              awaddr_o  <= {data_addr_i[AXI_ADDR_W-1:2], 2'b00};
              wdata_o   <= AXI_DATA_W'(data_wdata_i);
              wstrb_o   <= (AXI_DATA_W/8)'(data_be_i);
              awvalid_o <= 1'b1;
              wvalid_o  <= 1'b1;
              state_q   <= AWW;
            end else begin
              araddr_o  <= data_gnt_o ? {data_addr_i[AXI_ADDR_W-1:2], 2'b00}
                                      : {instr_addr_i[AXI_ADDR_W-1:2], 2'b00};
              arvalid_o <= 1'b1;
              state_q   <= AR;
            end
          end
        end

        AR: begin
          if (arready_i) begin
            arvalid_o <= 1'b0;
            rready_o  <= 1'b1;
            state_q   <= R;
          end
        end

        R: begin
          if (rvalid_i) begin
            rready_o <= 1'b0;
            if (owner_data_q) begin
              data_rdata_o  <= rdata_i[31:0];
              data_err_o    <= rresp_i[1];
              data_rvalid_o <= 1'b1;
            end else begin
              instr_rdata_o  <= rdata_i[31:0];
              instr_err_o    <= rresp_i[1];
              instr_rvalid_o <= 1'b1;
            end
            state_q <= RESP;
          end
        end

        AWW: begin
          // AW and W complete independently; a channel counts as done once its
          // valid has dropped or it handshakes this cycle.
          if (awvalid_o && awready_i) awvalid_o <= 1'b0;
          if (wvalid_o && wready_i)   wvalid_o  <= 1'b0;
          if ((!awvalid_o || awready_i) && (!wvalid_o || wready_i)) begin
            bready_o <= 1'b1;
            state_q  <= B;
          end
        end

        B: begin
          // Only the data port can issue writes.
          if (bvalid_i) begin
            bready_o      <= 1'b0;
            data_err_o    <= bresp_i[1];
            data_rvalid_o <= 1'b1;
            state_q       <= RESP;
          end
        end

        RESP: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob_ibex_axi_arb.sv
// Directed bench for iob_ibex_axi_arb: reset state, instruction read, data
// write with delayed W channel, arbitration on simultaneous requests, read
// error, reset mid-write and write error with a pending instruction request.
`timescale 1ns/1ps
module tb_iob_ibex_axi_arb;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [AW-1:0] instr_addr;
  logic [31:0]   instr_rdata;
  logic          data_req, data_gnt, data_we, data_rvalid, data_err;
  logic [3:0]    data_be;
  logic [AW-1:0] data_addr;
  logic [31:0]   data_wdata, data_rdata;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]    bresp, rresp;
  logic          arvalid, arready, rvalid, rready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iob_ibex_axi_arb #(
    .AXI_ADDR_W(AW),
    .AXI_DATA_W(DW),
    .ARB_HOLD  (0)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .instr_req_i   (instr_req),
    .instr_gnt_o   (instr_gnt),
    .instr_addr_i  (instr_addr),
    .instr_rvalid_o(instr_rvalid),
    .instr_rdata_o (instr_rdata),
    .instr_err_o   (instr_err),
    .data_req_i    (data_req),
    .data_gnt_o    (data_gnt),
    .data_we_i     (data_we),
    .data_be_i     (data_be),
    .data_addr_i   (data_addr),
    .data_wdata_i  (data_wdata),
    .data_rvalid_o (data_rvalid),
    .data_rdata_o  (data_rdata),
    .data_err_o    (data_err),
    .awvalid_o     (awvalid),
    .awready_i     (awready),
    .awaddr_o      (awaddr),
    .wvalid_o      (wvalid),
    .wready_i      (wready),
    .wdata_o       (wdata),
    .wstrb_o       (wstrb),
    .bvalid_i      (bvalid),
    .bready_o      (bready),
    .bresp_i       (bresp),
    .arvalid_o     (arvalid),
    .arready_i     (arready),
    .araddr_o      (araddr),
    .rvalid_i      (rvalid),
    .rready_o      (rready),
    .rdata_i       (rdata),
    .rresp_i       (rresp)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge; inputs are driven there and
  // outputs are checked 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_req = 0; instr_addr = '0;
    data_req = 0; data_we = 0; data_be = 0; data_addr = '0; data_wdata = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = '0; rresp = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick(); tick();
    rst = 0;
  endtask

  initial begin
    logic exp_data;
    int   k;

    // ---------------- reset state ----------------
    rst = 1;
    idle_inputs();
    instr_req = 1; data_req = 1;
    #1;
    chk("rst_instr_gnt", instr_gnt, 0);
    chk("rst_data_gnt", data_gnt, 0);
    tick(); tick();
    #1;
    chk("rst_valids", {awvalid, wvalid, arvalid, rready, bready}, 5'b0);
    chk("rst_rvalids", {instr_rvalid, data_rvalid, instr_err, data_err}, 4'b0);
    chk("rst_rdata", {instr_rdata, data_rdata}, 64'h0);
    chk("rst_gnt_held", {instr_gnt, data_gnt}, 2'b00);

    // ---------------- instruction read ----------------
    do_reset();
    instr_req = 1; instr_addr = 32'h0000_1006;
    arready = 1; rvalid = 1; rdata = 32'hDEADBEEF; rresp = 0;
    #1;
    chk("ird_gnt_c0", {instr_gnt, data_gnt}, 2'b10);
    tick(); instr_req = 0; #1;
    chk("ird_arvalid_c1", arvalid, 1);
    chk("ird_araddr", araddr, 32'h0000_1004);
    tick(); #1;
    chk("ird_rready_c2", {arvalid, rready}, 2'b01);
    chk("ird_no_rvalid_c2", instr_rvalid, 0);
    tick(); #1;
    chk("ird_rvalid_c3", {instr_rvalid, instr_err, data_rvalid}, 3'b100);
    chk("ird_rdata", instr_rdata, 32'hDEADBEEF);
    tick(); #1;
    chk("ird_pulse_end", instr_rvalid, 0);

    // ---------------- data write, W delayed ----------------
    do_reset();
    data_req = 1; data_we = 1; data_be = 4'h3; data_addr = 32'h0000_2000;
    data_wdata = 32'h1234_5678; awready = 1; wready = 0;
    #1;
    chk("wr_gnt_c0", {instr_gnt, data_gnt}, 2'b01);
    tick(); data_req = 0; #1;
    chk("wr_aw_w_c1", {awvalid, wvalid}, 2'b11);
    chk("wr_awaddr", awaddr, 32'h0000_2000);
    chk("wr_wstrb", wstrb, 4'h3);
    chk("wr_wdata", wdata, 32'h1234_5678);
    tick(); awready = 0; #1;
    chk("wr_c2", {awvalid, wvalid}, 2'b01);
    tick(); #1;
    chk("wr_c3", {awvalid, wvalid, bready}, 3'b010);
    tick(); wready = 1; #1;
    chk("wr_c4", {awvalid, wvalid, bready}, 3'b010);
    tick(); wready = 0; bvalid = 1; bresp = 0; #1;
    chk("wr_b_c5", {wvalid, bready, data_rvalid}, 3'b010);
    tick(); bvalid = 0; #1;
    chk("wr_resp_c6", {data_rvalid, data_err, instr_rvalid}, 3'b100);
    chk("wr_rdata_kept", data_rdata, 32'h0);
    tick(); #1;
    chk("wr_pulse_end", data_rvalid, 0);

    // ---------------- arbitration, 4 grants ----------------
    do_reset();
    instr_req = 1; instr_addr = 32'h100; data_req = 1; data_we = 0; data_addr = 32'h200;
    arready = 1; rvalid = 1; rdata = 32'h5555_AAAA;
    for (int g = 0; g < 4; g++) begin
`ifdef IOB_IBEX_AXI_ARB_RR_EN
      exp_data = (g % 2 == 0);
`else
      exp_data = 1'b1;
`endif
      #1;
      k = 0;
      while (k < 8 && !(instr_gnt || data_gnt)) begin
        tick(); #1;
        k++;
      end
      if (k == 8) chk($sformatf("arb_timeout_%0d", g), 0, 1);
      else chk($sformatf("arb_grant_%0d", g), {instr_gnt, data_gnt}, {!exp_data, exp_data});
      tick();
    end

    // ---------------- read error, back-to-back request ----------------
    do_reset();
    data_req = 1; data_we = 0; data_addr = 32'h0000_3003;
    arready = 1; rvalid = 1; rdata = 32'hCAFE_F00D; rresp = 2'b10;
    #1;
    chk("rerr_gnt_c0", data_gnt, 1);
    tick(); #1;
    chk("rerr_araddr", araddr, 32'h0000_3000);
    chk("rerr_nogrant_c1", data_gnt, 0);
    tick(); #1;
    chk("rerr_nogrant_c2", data_gnt, 0);
    tick(); #1;
    chk("rerr_resp_c3", {data_rvalid, data_err, instr_rvalid, data_gnt}, 4'b1100);
    chk("rerr_rdata", data_rdata, 32'hCAFE_F00D);
    tick(); #1;
    chk("rerr_next_gnt_c4", {data_gnt, data_rvalid, data_err}, 3'b100);

    // ---------------- reset during AWW ----------------
    do_reset();
    data_req = 1; data_we = 1; data_be = 4'hF; data_addr = 32'h40; data_wdata = 32'h1;
    #1;
    chk("rstw_gnt", data_gnt, 1);
    tick(); data_req = 0; #1;
    chk("rstw_aww", {awvalid, wvalid}, 2'b11);
    rst = 1;
    tick(); rst = 0;
    instr_req = 1; instr_addr = 32'h0000_0808;
    arready = 1; rvalid = 1; rdata = 32'h0BAD_CAFE; rresp = 0;
    #1;
    chk("rstw_dropped", {awvalid, wvalid, bready, data_rvalid, instr_rvalid}, 5'b0);
    chk("rstw_idle_gnt", instr_gnt, 1);
    tick(); instr_req = 0; tick(); tick(); #1;
    chk("rstw_read_done", {instr_rvalid, instr_err}, 2'b10);
    chk("rstw_read_data", instr_rdata, 32'h0BAD_CAFE);

    // ---------------- write error with pending instr request ----------------
    do_reset();
    data_req = 1; data_we = 1; data_be = 4'hF; data_addr = 32'h80; data_wdata = 32'h77;
    instr_req = 1; instr_addr = 32'h0000_0C00;
    awready = 1; wready = 1; bvalid = 1; bresp = 2'b11;
    arready = 1; rvalid = 1; rdata = 32'h0; rresp = 0;
    #1;
    chk("werr_gnt_c0", {instr_gnt, data_gnt}, 2'b01);
    tick(); data_req = 0; #1;
    chk("werr_c1", instr_gnt, 0);
    tick(); #1;
    chk("werr_c2", instr_gnt, 0);
    tick(); #1;
    chk("werr_resp_c3", {data_rvalid, data_err, instr_gnt}, 3'b110);
    tick(); #1;
    chk("werr_instr_gnt_c4", {instr_gnt, data_rvalid}, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case the stimulus itself ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
